// File: rtl/test_stream_seq_check_if.sv
// Stream bundle for the sequence checker.
// The master drives data/valid/last; the slave drives ready.
interface test_stream_seq_check_if #(
    parameter int DSIZE = 16
);
    logic [DSIZE-1:0] tdata;
    logic             tvalid;
    logic             tlast;
    logic             tready;

    modport master (
        output tdata,
        output tvalid,
        output tlast,
        input  tready
    );

    modport slave (
        input  tdata,
        input  tvalid,
        input  tlast,
        output tready
    );
endinterface

// File: rtl/test_stream_seq_check.sv
// One link of the pass chain: once armed, checks that an incoming stream
// carries an incrementing sequence of BEATS values, then passes downstream.
module test_stream_seq_check #(
    parameter int DSIZE   = 16,
    parameter int BEATS   = 256,
    parameter int START   = 0,
    parameter int TIMEOUT = 4096,
    parameter bit REPORT  = 1'b1
) (
    input  logic                         clock,
    input  logic                         rst,
    input  logic                         from_up_pass,
    test_stream_seq_check_if.slave       s,
    output logic                         to_down_pass,
    output logic                         test_fail,
    output logic [1:0]                   fail_code,
    output logic [15:0]                  beat_cnt
);

    localparam int TW = $clog2(TIMEOUT + 1);

    localparam logic [15:0]      LAST_IDX = 16'(BEATS - 1);
    localparam logic [TW-1:0]    TMO_LIM  = TW'(TIMEOUT - 1);
    localparam logic [DSIZE-1:0] START_V  = DSIZE'(START);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        PASS = 2'd2,
        FAIL = 2'd3
    } state_t;

    state_t           state;
    logic [DSIZE-1:0] exp_val;
    logic [TW-1:0]    tmo;
    logic             accept;
    logic             is_last;

    // ready is a pure decode of RUN so the stream never sees a bubble
    always_comb begin
        s.tready = (state == RUN);
        accept   = s.tvalid & s.tready;
        is_last  = (beat_cnt == LAST_IDX);
    end

    // main checker FSM; all flags are registered and sticky until reset
    always_ff @(posedge clock or posedge rst) begin
        if (rst) begin
            state        <= IDLE;
            exp_val      <= '0;
            tmo          <= '0;
            beat_cnt     <= '0;
            to_down_pass <= 1'b0;
            test_fail    <= 1'b0;
            fail_code    <= 2'd0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (from_up_pass) begin
                        state    <= RUN;
                        exp_val  <= START_V;
                        beat_cnt <= '0;
                        tmo      <= '0;
                    end
                end
                RUN: begin
                    if (accept) begin
                        if (s.tdata != exp_val) begin
                            state     <= FAIL;
                            test_fail <= 1'b1;
                            fail_code <= 2'd1;
                        end else if (s.tlast != is_last) begin
                            state     <= FAIL;
                            test_fail <= 1'b1;
                            fail_code <= 2'd2;
                            beat_cnt  <= beat_cnt + 16'd1;
                        end else begin
                            beat_cnt <= beat_cnt + 16'd1;
                            exp_val  <= exp_val + 1'b1;
                            tmo      <= '0;
                            if (is_last) begin
                                state        <= PASS;
                                to_down_pass <= 1'b1;
                            end
                        end
                    end else if (tmo == TMO_LIM) begin
                        state     <= FAIL;
                        test_fail <= 1'b1;
                        fail_code <= 2'd3;
                    end else begin
                        tmo <= tmo + 1'b1;
                    end
                end
                PASS: begin
                    state <= PASS;
                end
                FAIL: begin
                    state <= FAIL;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    generate
        if (REPORT) begin : g_report
            logic [DSIZE-1:0] got;
            logic             fail_q;

            // remember the last beat seen and announce the first FAIL cycle
            always_ff @(posedge clock or posedge rst) begin
                if (rst) begin
                    got    <= '0;
                    fail_q <= 1'b0;
                end else begin
                    if (accept) begin
                        got <= s.tdata;
                    end
                    fail_q <= test_fail;
                    if (test_fail && !fail_q) begin
                        $error("seq_check code=%0d beats=%0d exp=%0h got=%0h",
                               fail_code, beat_cnt, exp_val, got);
                    end
                end
            end
        end
    endgenerate

endmodule
